// File: rtl/cpc_rom_ctrl.sv
// Upper-ROM board controller: DFxx slot select, paired chip-select decode and
// 28C256 in-system programming sequencer with write-enable pulses and status port.
module cpc_rom_ctrl #(
    parameter int unsigned WE_CYCLES   = 2,
    parameter int unsigned PAGE_WINDOW = 400,
    parameter int unsigned TWC_CYCLES  = 40000,
    parameter logic [7:0]  STATUS_ADDR = 8'hDF
) (
    input  logic        CLK,
    input  logic        RESET_B,
    input  logic [15:0] A,
    input  logic [7:0]  D,
    input  logic        IOREQ_B,
    input  logic        MREQ_B,
    input  logic        RD_B,
    input  logic        WR_B,
    input  logic        ROMEN_B,
    input  logic        bank,
    input  logic [7:0]  slot_en,
    input  logic [3:0]  eeprom_en,
    input  logic        prog_en,
    output logic [3:0]  romcs_b,
    output logic        rom_a14,
    output logic        romdis,
    output logic [3:0]  we_b,
    output logic        busy,
    output logic [7:0]  dout,
    output logic        dout_oe
);

    localparam int unsigned CW = 16;
    localparam int unsigned TW = 11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PAGE = 2'd1,
        S_BUSY = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [7:0]      romsel;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [CW-1:0]   we_cnt;
    logic [TW-1:0]   tag, tag_nxt;
    logic            overrun, overrun_nxt;
    logic            iowr_q, memwr_q, stsrd_q;
    logic            accept, set_ovr;

    logic            iowr, memwr, stsrd, hit, wr_edge;
    logic [1:0]      pair;
    logic [TW-1:0]   cur_tag;

    // Address bits below the page boundary never influence the controller.
    logic            unused_addr;
    assign unused_addr = &{1'b0, A[5:0]};

    assign iowr    = !IOREQ_B && !WR_B && !A[13];
    assign pair    = romsel[2:1];
    assign hit     = (romsel[7:4] == 4'h0) && (romsel[3] == bank) && slot_en[romsel[2:0]];
    assign memwr   = !MREQ_B && !WR_B && (A[15:14] == 2'b11) && prog_en && hit && eeprom_en[pair];
    assign wr_edge = memwr && !memwr_q;
    assign stsrd   = !IOREQ_B && !RD_B && (A[15:8] == STATUS_ADDR) && prog_en;
    assign cur_tag = {romsel[2:0], A[13:6]};

    assign romdis  = hit;
    assign rom_a14 = romsel[0];
    assign busy    = (state != S_IDLE);
    assign dout_oe = stsrd;
    assign dout    = {busy, overrun, (state == S_PAGE), romsel[4:0]};

    // Pair chip-select decode for the upper ROM window.
    always_comb begin
        romcs_b = 4'hF;
        if (hit && !ROMEN_B && (A[15:14] == 2'b11)) begin
            romcs_b[pair] = 1'b0;
        end
    end

    // Page-window / write-cycle sequencer.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tag_nxt   = tag;
        accept    = 1'b0;
        set_ovr   = 1'b0;
        case (state)
            S_IDLE: begin
                if (wr_edge) begin
                    accept    = 1'b1;
                    tag_nxt   = cur_tag;
                    cnt_nxt   = CW'(PAGE_WINDOW);
                    state_nxt = S_PAGE;
                end
            end
            S_PAGE: begin
                if (wr_edge && (cur_tag == tag)) begin
                    accept  = 1'b1;
                    cnt_nxt = CW'(PAGE_WINDOW);
                end else begin
                    set_ovr = wr_edge;
                    if (cnt <= CW'(1)) begin
                        cnt_nxt   = CW'(TWC_CYCLES);
                        state_nxt = S_BUSY;
                    end else begin
                        cnt_nxt = cnt - CW'(1);
                    end
                end
            end
            S_BUSY: begin
                set_ovr = wr_edge;
                if (cnt <= CW'(1)) begin
                    cnt_nxt   = '0;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = S_IDLE;
            end
        endcase

        overrun_nxt = overrun;
        if (set_ovr) begin
            overrun_nxt = 1'b1;
        end else if (!stsrd && stsrd_q) begin
            overrun_nxt = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            state   <= S_IDLE;
            cnt     <= '0;
            tag     <= '0;
            overrun <= 1'b0;
            romsel  <= 8'h00;
            iowr_q  <= 1'b0;
            memwr_q <= 1'b0;
            stsrd_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            tag     <= tag_nxt;
            overrun <= overrun_nxt;
            iowr_q  <= iowr;
            memwr_q <= memwr;
            stsrd_q <= stsrd;
            if (iowr && !iowr_q) begin
                romsel <= D;
            end
        end
    end

    // Write-enable pulse: ends on WR_B high or after WE_CYCLES edges.
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            we_b   <= 4'hF;
            we_cnt <= '0;
        end else if (accept) begin
            we_b   <= ~(4'b0001 << pair);
            we_cnt <= CW'(WE_CYCLES);
        end else if (we_b != 4'hF) begin
            if (WR_B || (we_cnt <= CW'(1))) begin
                we_b <= 4'hF;
            end else begin
                we_cnt <= we_cnt - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_cpc_rom_ctrl.sv
// Scoreboard bench for cpc_rom_ctrl: a time-based reference model predicts
// write pulses, status bytes and decode outputs; a monitor compares them.
module tb_cpc_rom_ctrl;

    localparam int WE  = 2;
    localparam int PW  = 400;
    localparam int TWC = 40000;

    logic        CLK = 1'b0;
    logic        RESET_B = 1'b0;
    logic [15:0] A = 16'h0000;
    logic [7:0]  D = 8'h00;
    logic        IOREQ_B = 1'b1, MREQ_B = 1'b1, RD_B = 1'b1, WR_B = 1'b1, ROMEN_B = 1'b1;
    logic        bank = 1'b0;
    logic [7:0]  slot_en = 8'h00;
    logic [3:0]  eeprom_en = 4'h0;
    logic        prog_en = 1'b0;
    logic [3:0]  romcs_b, we_b;
    logic        rom_a14, romdis, busy, dout_oe;
    logic [7:0]  dout;

    cpc_rom_ctrl #(.WE_CYCLES(WE), .PAGE_WINDOW(PW), .TWC_CYCLES(TWC), .STATUS_ADDR(8'hDF)) dut (
        .CLK(CLK), .RESET_B(RESET_B), .A(A), .D(D), .IOREQ_B(IOREQ_B), .MREQ_B(MREQ_B),
        .RD_B(RD_B), .WR_B(WR_B), .ROMEN_B(ROMEN_B), .bank(bank), .slot_en(slot_en),
        .eeprom_en(eeprom_en), .prog_en(prog_en), .romcs_b(romcs_b), .rom_a14(rom_a14),
        .romdis(romdis), .we_b(we_b), .busy(busy), .dout(dout), .dout_oe(dout_oe)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Reference model: the sequencer is described by the edge of the last accepted write.
    logic [7:0]  m_romsel = 8'h00;
    logic        m_act = 1'b0;
    int          m_k = 0;
    logic [10:0] m_tag = '0;
    logic        m_ovr = 1'b0;

    int          q_pair[$];
    int          q_wid[$];
    logic [7:0]  q_sts[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // 0 = idle, 1 = page window, 2 = write cycle, after n clock edges.
    function automatic int st_at(input int n);
        if (!m_act) return 0;
        if (n < m_k + PW) return 1;
        if (n < m_k + PW + TWC) return 2;
        return 0;
    endfunction

    function automatic logic m_hit();
        return (m_romsel[7:4] == 4'h0) && (m_romsel[3] == bank) && slot_en[m_romsel[2:0]];
    endfunction

    task automatic model_reset();
        m_romsel = 8'h00;
        m_act    = 1'b0;
        m_ovr    = 1'b0;
    endtask

    // Monitor: decode outputs every cycle, status bytes and write pulses from the scoreboard.
    bit         in_pulse = 1'b0;
    int         w_cnt = 0;
    int         cur_w = 0;
    logic [3:0] cur_pat = 4'hF;

    always @(negedge CLK) begin
        logic [3:0] cs_e;
        #1;
        cs_e = 4'hF;
        if (m_hit() && !ROMEN_B && (A[15:14] == 2'b11)) cs_e[m_romsel[2:1]] = 1'b0;
        chk("romdis", romdis, m_hit());
        chk("rom_a14", rom_a14, m_romsel[0]);
        chk("romcs_b", romcs_b, cs_e);
        chk("busy", busy, st_at(cyc) != 0);
        chk("dout_oe", dout_oe, !IOREQ_B && !RD_B && (A[15:8] == 8'hDF) && prog_en);
        if (dout_oe) begin
            if (q_sts.size() == 0) chk("status_pending", q_sts.size(), 1);
            else chk("status", dout, q_sts.pop_front());
        end
        if (we_b != 4'hF) begin
            if (!in_pulse) begin
                in_pulse = 1'b1;
                w_cnt    = 1;
                if (q_pair.size() == 0) begin
                    chk("we_pending", q_pair.size(), 1);
                    cur_pat = we_b;
                    cur_w   = 0;
                end else begin
                    cur_pat = ~(4'b0001 << q_pair.pop_front());
                    cur_w   = q_wid.pop_front();
                    chk("we_pattern", we_b, cur_pat);
                end
            end else begin
                w_cnt++;
                chk("we_hold", we_b, cur_pat);
            end
        end else if (in_pulse) begin
            in_pulse = 1'b0;
            chk("we_width", w_cnt, cur_w);
        end
    end

    task automatic io_write(input logic [7:0] data);
        A = {8'hDF, 8'($urandom)};
        D = data;
        IOREQ_B = 1'b0;
        WR_B = 1'b0;
        @(negedge CLK);
        m_romsel = data;
        IOREQ_B = 1'b1;
        WR_B = 1'b1;
        @(negedge CLK);
    endtask

    task automatic mem_read(input logic [15:0] addr, input logic romen, input int hold);
        A = addr;
        MREQ_B = 1'b0;
        RD_B = 1'b0;
        ROMEN_B = romen;
        repeat (hold) @(negedge CLK);
        MREQ_B = 1'b1;
        RD_B = 1'b1;
        ROMEN_B = 1'b1;
        @(negedge CLK);
    endtask

    task automatic mem_write(input logic [15:0] addr, input int hold, input bit rst_mid);
        int st;
        bit ok;
        logic [10:0] tg;
        int pr;
        A = addr;
        MREQ_B = 1'b0;
        WR_B = 1'b0;
        ok = prog_en && m_hit() && eeprom_en[m_romsel[2:1]];
        st = st_at(cyc);
        tg = {m_romsel[2:0], addr[13:6]};
        pr = int'(m_romsel[2:1]);
        @(negedge CLK);
        if (ok) begin
            if (st == 0 || (st == 1 && tg == m_tag)) begin
                m_act = 1'b1;
                m_k   = cyc;
                m_tag = tg;
                q_pair.push_back(pr);
                q_wid.push_back(hold < WE ? hold : WE);
            end else begin
                m_ovr = 1'b1;
            end
        end
        if (rst_mid) begin
            #1 chk("we_low_before_reset", we_b != 4'hF, 1);
            #1 RESET_B = 1'b0;
            model_reset();
            #1 chk("reset_async_we_b", we_b, 4'hF);
            chk("reset_async_busy", busy, 0);
        end
        repeat (hold - 1) @(negedge CLK);
        MREQ_B = 1'b1;
        WR_B = 1'b1;
        @(negedge CLK);
    endtask

    task automatic status_read(input int hold);
        int s;
        logic [7:0] e;
        A = {8'hDF, 8'($urandom)};
        IOREQ_B = 1'b0;
        RD_B = 1'b0;
        if (prog_en) begin
            for (int i = 0; i < hold; i++) begin
                s = st_at(cyc + i);
                e = {(s != 0), m_ovr, (s == 1), m_romsel[4:0]};
                q_sts.push_back(e);
            end
        end
        repeat (hold) @(negedge CLK);
        IOREQ_B = 1'b1;
        RD_B = 1'b1;
        @(negedge CLK);
        if (prog_en) m_ovr = 1'b0;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge CLK);
    endtask

    initial begin
        int t0, s, pg;
        logic [15:0] addr;
        slot_en    = 8'($urandom);
        slot_en[0] = 1'b0;
        slot_en[5] = 1'b1;
        eeprom_en  = 4'($urandom);
        repeat (3) @(negedge CLK);
        RESET_B = 1'b1;
        chk("reset_romdis", romdis, 0);
        chk("reset_rom_a14", rom_a14, 0);
        chk("reset_we_b", we_b, 4'hF);
        chk("reset_busy", busy, 0);
        chk("reset_dout_oe", dout_oe, 0);
        @(negedge CLK);

        // Slot select and chip-select decode.
        io_write(8'h05);
        chk("sel5_romdis", romdis, 1);
        chk("sel5_rom_a14", rom_a14, 1);
        A = 16'hC000;
        MREQ_B = 1'b0;
        RD_B = 1'b0;
        ROMEN_B = 1'b0;
        #1 chk("sel5_romcs_b", romcs_b, 4'b1011);
        @(negedge CLK);
        MREQ_B = 1'b1;
        RD_B = 1'b1;
        ROMEN_B = 1'b1;
        @(negedge CLK);
        io_write(8'h08);
        chk("sel8_romdis", romdis, 0);
        for (int i = 0; i < 10; i++) begin
            bank = 1'($urandom);
            io_write(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15)));
            mem_read(16'($urandom), 1'($urandom), $urandom_range(1, 3));
        end

        // Three writes into one page, 100 cycles apart.
        bank = 1'b0;
        slot_en[2] = 1'b1;
        slot_en[3] = 1'b1;
        eeprom_en[1] = 1'b1;
        prog_en = 1'b1;
        io_write(8'h02);
        for (int i = 0; i < 3; i++) begin
            t0 = cyc;
            mem_write(16'hC000 + 16'(i), $urandom_range(1, 4), 1'b0);
            if (i < 2) wait_until(t0 + 100);
        end
        status_read(1);
        mem_write(16'hC040, 2, 1'b0);
        status_read(1);
        status_read(1);
        wait_until(m_k + PW - 2);
        status_read(4);

        // Writes during the write cycle.
        status_read(1);
        prog_en = 1'b0;
        mem_write(16'hC003, 2, 1'b0);
        prog_en = 1'b1;
        status_read(1);
        mem_write(16'hC003, 2, 1'b0);
        status_read(1);
        status_read(1);
        wait_until(m_k + PW + TWC - 2);
        status_read(4);

        // Random page traffic with slot changes.
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 3) == 0) io_write(($urandom_range(0, 1) != 0) ? 8'h02 : 8'h03);
            pg = $urandom_range(0, 1);
            addr = 16'hC000 | 16'(pg << 6) | 16'($urandom_range(0, 63));
            mem_write(addr, $urandom_range(1, 4), 1'b0);
            repeat ($urandom_range(0, 10)) @(negedge CLK);
            if ($urandom_range(0, 2) == 0) status_read($urandom_range(1, 2));
        end

        // Reset while a write pulse is active.
        s = st_at(cyc);
        if (s == 1) begin
            io_write({5'b00000, m_tag[10:8]});
            addr = {2'b11, m_tag[7:0], 6'h05};
        end else begin
            io_write(8'h02);
            addr = 16'hC000;
        end
        mem_write(addr, 1, 1'b1);
        repeat (2) @(negedge CLK);
        RESET_B = 1'b1;
        @(negedge CLK);
        chk("post_reset_rom_a14", rom_a14, 0);
        chk("post_reset_busy", busy, 0);
        repeat (5) @(negedge CLK);
        chk("we_queue_drained", q_pair.size(), 0);
        chk("status_queue_drained", q_sts.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog actual=cycle_%0d required=finish", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpc_rom_ctrl.md
# cpc_rom_ctrl

Synchronous controller for the eight-slot CPC ROM board, clocked from the CPC bus clock. It owns the upper-ROM select register written through port DFxx, and decodes the paired 28C256 chip selects, ROMDIS and ROM A14. It also sequences in-system EEPROM programming: it generates write-enable pulses, tracks 28C256 page-write windows and the write-cycle busy time, and reports status on an I/O read port.

## Interface
- WE_CYCLES, 2: maximum we_b low time in CLK cycles
- PAGE_WINDOW, 400: page byte-load window in cycles (100 us at 4 MHz, below 28C256 tBLC)
- TWC_CYCLES, 40000: write-cycle busy time in cycles (10 ms at 4 MHz)
- STATUS_ADDR, 8'hDF: A[15:8] value of the status read port
- CLK  in  1  CPC bus clock; all state changes on the rising edge
- RESET_B  in  1  asynchronous, active-low reset
- A  in  16  Z80 address bus
- D  in  8  Z80 data bus
- IOREQ_B, MREQ_B, RD_B, WR_B, ROMEN_B  in  1 each  Z80/CPC strobes, active low
- bank  in  1  bank jumper; must equal romsel[3]
- slot_en  in  8  DIP enables for slots 0-7
- eeprom_en  in  4  per-pair flag: pair holds an EEPROM (writable)
- prog_en  in  1  programming jumper
- romcs_b  out  4  pair chip selects (pairs 01, 23, 45, 67), active low
- rom_a14  out  1  ROM A14 = romsel[0]
- romdis  out  1  ROMDIS drive
- we_b  out  4  per-pair EEPROM write enable, active low
- busy  out  1  page window or write cycle in progress
- dout  out  8  status byte
- dout_oe  out  1  status byte drive enable

## Operation
- Select write: iowr = !IOREQ_B & !WR_B & !A[13]. On the first edge where iowr is sampled high after a low sample, romsel <= D.
- Hit: hit = romsel[7:4]==0 & romsel[3]==bank & slot_en[romsel[2:0]]. Hit is combinational from registered romsel.
- romdis = hit. This is independent of the bus cycle.
- romcs_b[p] is low when all of these hold: hit, romsel[2:1]==p, !ROMEN_B, A[15:14]==2'b11. These are combinational outputs.
- EEPROM write qualifier: memwr = !MREQ_B & !WR_B & A[15:14]==2'b11 & prog_en & hit & eeprom_en[romsel[2:1]]. Writes are acted on at the memwr rising-edge sample.
- Page tag = {romsel[2:0], A[13:6]}, latched at the first accepted write.
- States:
  - IDLE, on a write: pulse, latch tag, load window counter = PAGE_WINDOW, go to PAGE.
  - PAGE, on a write with a matching tag: pulse, reload the window counter.
  - PAGE, on a write with a mismatched tag: drop the write and set overrun.
  - PAGE, when the counter reaches 0 with no write on that edge: load TWC_CYCLES, go to BUSY.
  - BUSY, on any write: drop it and set overrun.
  - BUSY, when the counter reaches 0: go to IDLE.
- Simultaneous events in PAGE: a write accepted on the terminal-count edge takes priority and reloads the window.
- Pulse behaviour:
  - we_b[romsel[2:1]] goes low from the accepting edge.
  - It returns high at the first edge where WR_B is sampled high, or after WE_CYCLES edges, whichever comes first.
  - Only one bit of we_b is ever low at a time.
- Status read: stsrd = !IOREQ_B & !RD_B & A[15:8]==STATUS_ADDR & prog_en.
  - dout_oe = stsrd, combinational.
  - dout = {busy, overrun, state==PAGE, romsel[4:0]}.
  - overrun clears on the edge where stsrd is first sampled low after being high.
- busy = (state != IDLE).
- Counters are 16-bit down counters. Every parameter value must be at least 1 and at most 65535.

## Timing
- Reset values:
  - romsel=8'h00, state=IDLE, counters=0, overrun=0.
  - we_b=4'hF, busy=0, dout_oe=0.
  - romdis and romcs_b follow from romsel=0.
- Select latency: romsel updates 1 edge after iowr is first sampled. Decode outputs follow combinationally.
- we_b latency:
  - Low 1 edge after memwr is first sampled.
  - Width: 1 to WE_CYCLES cycles.
  - It must never remain low after WR_B has been sampled high.
- Page window: the last accepted write plus PAGE_WINDOW edges, then BUSY.
- busy is high for TWC_CYCLES edges, then IDLE.
- A romsel change during PAGE or BUSY does not abort the sequence. The tag retains the original slot, and later writes to another slot are dropped with overrun set.
- Reset asserted mid-operation: we_b is forced high immediately (asynchronously) and all state is cleared; no write cycle completes.
- A level-held strobe is counted once; a write re-arms only after memwr or iowr has been sampled low.

## Test plan
- Reset with all strobes idle -> romsel=00, romdis=0 if slot_en[0]=0, we_b=F, busy=0, dout_oe=0.
- OUT &DF00,5 with bank=0 and slot_en[5]=1 -> romsel=05 1 edge later; romdis=1, rom_a14=1. A read of C000 with ROMEN_B=0 gives romcs_b=4'b1011. OUT &DF00,8 with bank=0 -> romdis=0.
- prog_en=1 with pair 23 writable, romsel=02, 3 writes to C000-C002 spaced 100 cycles apart -> 3 we_b[1] pulses, each of 2 cycles or fewer. busy=1 throughout; BUSY is entered 400 cycles after the third write, and IDLE follows 40000 cycles later.
- In PAGE, a write to C040 (different page) -> no we_b pulse, status bit 6=1. A status read of &DFxx returns 8'hE2; after that read ends, bit 6 reads 0.
- Write during BUSY, and a write with prog_en=0 -> no pulse, state unchanged. The write during BUSY sets overrun; the write with prog_en=0 does not.
- RESET_B asserted while we_b is low -> we_b=F before the next edge, busy=0, romsel=00.
